// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: loads a byte, steps an external 8:1 mux select through it and
// serialises the mux output Y into a registered bit stream with hold and done.
module mux_scan_ctrl #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       hold,
  output logic [7:0] d_out,
  output logic [2:0] sel,
  input  logic       y_in,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] SEL_STEP  = MSB_FIRST ? 3'd7 : 3'd1;
  state_t     state_q, state_d;
  logic [7:0] d_out_q, d_out_d;
  logic [2:0] sel_q, sel_d, cnt_q, cnt_d;
  logic       ser_out_q, ser_out_d, ser_valid_q, ser_valid_d, done_q, done_d;
  logic       load, step, last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_out_q     <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_out_q     <= d_out_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    load    = (state_q == IDLE) && start;
    step    = (state_q == SHIFT) && !hold;
    last    = step && (cnt_q == 3'd7);
    state_d = (state_q == IDLE) ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  // stepping by 7 is a decrement modulo 8; the 8th step wraps sel back to its start
  always_comb begin
    d_out_d     = load ? din : d_out_q;
    sel_d       = load ? SEL_START : (step ? sel_q + SEL_STEP : sel_q);
    cnt_d       = load ? 3'd0 : (step ? cnt_q + 3'd1 : cnt_q);
    ser_out_d   = step ? y_in : ser_out_q;
    ser_valid_d = step;
    done_d      = last;
  end
  assign d_out     = d_out_q;
  assign sel       = sel_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed vectors for LSB-first and MSB-first instances
// sharing one stimulus, each closed through its own behavioural 8:1 mux.
module tb_mux_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = '0;
  logic       hold = 1'b0;
  logic [7:0] dout_a, dout_b;
  logic [2:0] sel_a, sel_b;
  logic       y_a, y_b, ser_a, ser_b, val_a, val_b, busy_a, busy_b, done_a, done_b;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  assign y_a = dout_a[sel_a];
  assign y_b = dout_b[sel_b];

  mux_scan_ctrl #(.MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .hold(hold),
    .d_out(dout_a), .sel(sel_a), .y_in(y_a), .ser_out(ser_a),
    .ser_valid(val_a), .busy(busy_a), .done(done_a));
  mux_scan_ctrl #(.MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .hold(hold),
    .d_out(dout_b), .sel(sel_b), .y_in(y_b), .ser_out(ser_b),
    .ser_valid(val_b), .busy(busy_b), .done(done_b));

  typedef struct {
    logic       start;
    logic [7:0] din;
    logic       hold;
    logic [2:0] sa, sb;
    logic       oa, ob, v, b, d;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic st, input logic [7:0] di, input logic hd,
                              input logic [2:0] sa, input logic [2:0] sb,
                              input logic oa, input logic ob, input logic v,
                              input logic b, input logic d, input logic [7:0] dout);
    vec_t r;
    r.start = st; r.din = di; r.hold = hd; r.sa = sa; r.sb = sb;
    r.oa = oa; r.ob = ob; r.v = v; r.b = b; r.d = d; r.dout = dout;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string nm, input logic v, input logic b, input logic d,
                          input logic [7:0] dout);
    chk({nm, " valid_a"}, {7'd0, val_a}, {7'd0, v});
    chk({nm, " valid_b"}, {7'd0, val_b}, {7'd0, v});
    chk({nm, " busy_a"}, {7'd0, busy_a}, {7'd0, b});
    chk({nm, " busy_b"}, {7'd0, busy_b}, {7'd0, b});
    chk({nm, " done_a"}, {7'd0, done_a}, {7'd0, d});
    chk({nm, " done_b"}, {7'd0, done_b}, {7'd0, d});
    chk({nm, " dout_a"}, dout_a, dout);
    chk({nm, " dout_b"}, dout_b, dout);
  endtask

  task automatic chk_zero(input string nm);
    chk_both(nm, 1'b0, 1'b0, 1'b0, 8'h00);
    chk({nm, " sel_a"}, {5'd0, sel_a}, 8'd0);
    chk({nm, " sel_b"}, {5'd0, sel_b}, 8'd0);
    chk({nm, " ser_a"}, {7'd0, ser_a}, 8'd0);
    chk({nm, " ser_b"}, {7'd0, ser_b}, 8'd0);
  endtask

  initial begin
    logic [7:0] w;
    int nbits, hcnt;
    logic hd;
    tbl.push_back(mk(1, 8'hA5, 0, 0, 7, 0, 0, 0, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 1, 6, 1, 1, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 2, 5, 0, 0, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 3, 4, 1, 1, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 4, 3, 0, 0, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 5, 2, 0, 0, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 6, 1, 1, 1, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 7, 0, 0, 0, 1, 1, 0, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 0, 0, 7, 1, 1, 1, 0, 1, 8'hA5));
    tbl.push_back(mk(0, 8'hA5, 1, 0, 7, 1, 1, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 8'h01, 0, 0, 7, 1, 1, 0, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 1, 6, 1, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 2, 5, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(1, 8'hFF, 1, 2, 5, 0, 0, 0, 1, 0, 8'h01));
    tbl.push_back(mk(1, 8'hFF, 1, 2, 5, 0, 0, 0, 1, 0, 8'h01));
    tbl.push_back(mk(1, 8'hFF, 1, 2, 5, 0, 0, 0, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 3, 4, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 4, 3, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 5, 2, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 6, 1, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 7, 0, 0, 0, 1, 1, 0, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 0, 7, 0, 1, 1, 0, 1, 8'h01));
    tbl.push_back(mk(0, 8'h01, 0, 0, 7, 0, 1, 0, 0, 0, 8'h01));

    #1;
    chk_zero("reset");
    tick;
    tick;
    #2 rst_n = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].start; din = tbl[i].din; hold = tbl[i].hold;
      tick;
      chk($sformatf("row%0d sel_a", i), {5'd0, sel_a}, {5'd0, tbl[i].sa});
      chk($sformatf("row%0d sel_b", i), {5'd0, sel_b}, {5'd0, tbl[i].sb});
      chk($sformatf("row%0d ser_a", i), {7'd0, ser_a}, {7'd0, tbl[i].oa});
      chk($sformatf("row%0d ser_b", i), {7'd0, ser_b}, {7'd0, tbl[i].ob});
      chk_both($sformatf("row%0d", i), tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].dout);
    end
    start = 1'b0; hold = 1'b0;

    // back-to-back frames with start held high; din changes mid-frame are ignored
    start = 1'b1; din = 8'hFF;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 8'hFF : 8'h00;
      tick;
      chk_both($sformatf("b2b%0d load", f), 1'b0, 1'b1, 1'b0, w);
      din = (f == 0) ? 8'h00 : 8'hAA;
      for (int i = 0; i < 8; i++) begin
        tick;
        chk($sformatf("b2b%0d bit%0d ser_a", f, i), {7'd0, ser_a}, {7'd0, w[i]});
        chk($sformatf("b2b%0d bit%0d ser_b", f, i), {7'd0, ser_b}, {7'd0, w[7-i]});
        chk_both($sformatf("b2b%0d bit%0d", f, i), 1'b1, i != 7, i == 7, w);
      end
      if (f == 1) start = 1'b0;
    end
    tick;
    chk_both("b2b idle", 1'b0, 1'b0, 1'b0, 8'h00);

    // async reset in the middle of a frame
    start = 1'b1; din = 8'h3C;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk_both("pre-reset", 1'b1, 1'b1, 1'b0, 8'h3C);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    tick;
    chk_zero("reset held");
    #2 rst_n = 1'b1;
    tick;
    chk_zero("idle after reset");

    // full 3C frame with a 3-cycle hold after the second bit
    w = 8'h3C;
    start = 1'b1; din = w;
    tick;
    start = 1'b0;
    chk_both("hold load", 1'b0, 1'b1, 1'b0, w);
    nbits = 0; hcnt = 0;
    for (int c = 0; c < 20 && nbits < 8; c++) begin
      hd = (nbits == 2) && (hcnt < 3);
      if (hd) hcnt++;
      hold = hd;
      tick;
      if (hd) begin
        chk($sformatf("hold%0d valid_a", hcnt), {7'd0, val_a}, 8'd0);
        chk($sformatf("hold%0d valid_b", hcnt), {7'd0, val_b}, 8'd0);
        chk($sformatf("hold%0d busy_a", hcnt), {7'd0, busy_a}, 8'd1);
        chk($sformatf("hold%0d ser_a", hcnt), {7'd0, ser_a}, {7'd0, w[1]});
      end else begin
        chk($sformatf("hf bit%0d ser_a", nbits), {7'd0, ser_a}, {7'd0, w[nbits]});
        chk($sformatf("hf bit%0d ser_b", nbits), {7'd0, ser_b}, {7'd0, w[7-nbits]});
        chk($sformatf("hf bit%0d valid_a", nbits), {7'd0, val_a}, 8'd1);
        chk($sformatf("hf bit%0d done_a", nbits), {7'd0, done_a}, {7'd0, nbits == 7});
        chk($sformatf("hf bit%0d done_b", nbits), {7'd0, done_b}, {7'd0, nbits == 7});
        nbits++;
      end
      chk($sformatf("hf c%0d sel_a", c), {5'd0, sel_a}, 8'(nbits % 8));
      chk($sformatf("hf c%0d sel_b", c), {5'd0, sel_b}, 8'((7 - nbits) & 7));
      chk($sformatf("hf c%0d dout_a", c), dout_a, w);
    end
    hold = 1'b0;
    chk("hold frame bit count", 8'(nbits), 8'd8);
    chk("hold frame hold cycles", 8'(hcnt), 8'd3);
    tick;
    chk_both("hold frame idle", 1'b0, 1'b0, 1'b0, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
